regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Instruction sequencer that sits directly upstream of the 8-entry × 8-bit register file and drives its data, address and write-enable. It also consumes the register file's read data and holds it in an accumulator. It accepts one 2-bit-opcode instruction at a time over a valid/ready handshake and sequences the register file's single shared address port. Supported operations: load-immediate, accumulate, store-accumulator and clear.

## Interface
Parameters:
- DW, 8, data width; must match the register file (8).
- AW, 3, register address width; must match the register file (3).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low. Asserted 0: all state cleared immediately.
- instr_valid  in  1  instruction present on op/rsel/imm.
- instr_ready  out  1  high exactly when in IDLE, including while rst=0.
- op  in  2  opcode: 00 LDI, 01 ADD, 10 ST, 11 CLR.
- rsel  in  AW  target/source register index.
- imm  in  DW  immediate for LDI; ignored otherwise.
- rf_d  out  DW  write data to register file d.
- rf_n  out  AW  address to register file n (shared read/write).
- rf_w  out  1  write enable to register file w.
- rf_q  in  DW  combinational read data from register file q.
- acc  out  DW  accumulator.
- carry  out  1  carry out of last ADD.
- done  out  1  one-cycle pulse at instruction completion.

## Operation
- Acceptance: an instruction is taken on a rising edge where instr_valid=1 and instr_ready=1. At that edge, op, rsel and imm are latched. Inputs are don't-care after that edge.
- FSM states: IDLE, RD, WR, DONE.
  - IDLE, on accept: LDI→WR, ST→WR, ADD→RD, CLR→DONE.
  - RD→DONE, WR→DONE, DONE→IDLE, all unconditional.
- rf_n is driven from the latched rsel in every state and holds its value in IDLE. rf_d and rf_n are registered outputs.
- RD (ADD):
  - rf_w=0.
  - At the exiting edge: {carry, acc} <= acc + rf_q, computed as a 9-bit sum. The 8-bit result wraps and carry takes bit 8.
- WR:
  - rf_w=1 for exactly this one cycle.
  - rf_d = latched imm for LDI, or the current acc for ST.
  - acc and carry are unchanged.
- CLR: acc<=0 and carry<=0 on the accept edge.
- DONE: done=1 for one cycle; rf_w=0.
- rf_w is 0 in every state except WR.
- Any instr_valid that arrives while not in IDLE is not accepted. The producer must hold it until instr_ready=1.
- Reset mid-operation:
  - The FSM returns to IDLE immediately.
  - rf_w drops to 0 asynchronously, so no partial write reaches the register file.
  - acc and carry are cleared.
  - Register-file contents are cleared only by the register file's own reset, not by this block.

## Timing
Reset values:
- instr_ready=1, rf_w=0, done=0.
- rf_d=0, rf_n=0, acc=0, carry=0.
- FSM in IDLE.

Cycle numbering takes the accept edge as edge 0; cycle 1 follows it.
- LDI/ST: rf_w=1 in cycle 1, and the register file captures the write at edge 1. done=1 in cycle 2. instr_ready=1 in cycle 3, so the next instruction is accepted at edge 3 at the earliest.
- ADD: rf_n is valid in cycle 1 and acc updates at edge 1. done=1 in cycle 2, and acc/carry are visible from cycle 2. Throughput is one instruction per 3 cycles.
- CLR: acc=0 from cycle 1. done=1 in cycle 1. Next accept at edge 2 at the earliest.
- Read-after-write: an ADD immediately following an LDI to the same register reads the new value. The write commits at edge 1 and the ADD's RD cycle occurs at the earliest in cycle 4.
- A ST following an ADD stores the post-ADD acc.

## Test plan
- Reset: hold rst=0 across several clocks with instr_valid=1 → instr_ready=1, rf_w=0, acc=0x00, carry=0, done never asserted. After release, the first instruction is accepted on the next edge.
- Load and accumulate:
  - Stimulus: LDI r3=0x5A, then ADD r3.
  - rf_w=1 exactly one cycle with rf_n=3 and rf_d=0x5A.
  - acc=0x5A, carry=0.
  - done pulses once per instruction, 2 cycles after each accept.
- Wrap and carry: after the above, LDI r1=0xF0 then ADD r1 → acc=0x4A, carry=1. A further CLR gives acc=0x00, carry=0, with done in the cycle after accept.
- Store: with acc=0x4A, ST r7 → rf_w=1 for one cycle with rf_n=7 and rf_d=0x4A. A subsequent ADD r7 gives acc=0x94.
- Handshake: hold instr_valid=1 continuously with a queue of 4 LDIs → instr_ready is low in cycles 1–2 after each accept. Exactly 4 writes occur, spaced 3 cycles apart, with no duplicated or dropped instruction.
- Reset mid-op: assert rst=0 asynchronously mid-cycle during the WR cycle of LDI r2=0xAA → rf_w falls immediately, acc=0 and the FSM is in IDLE. No done pulse occurs.

Source files
------------

// File: rtl/regfile_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_ctrl
//
// Instruction sequencer for an 8-entry x 8-bit register file with a single
// shared address port. It accepts one instruction at a time over a
// valid/ready handshake and then drives the register file's address, write
// data and write enable. It also keeps an accumulator that is fed from the
// register file's combinational read data.
//
// Opcodes: 00 LDI  rf[rsel] <= imm
//          01 ADD  {carry, acc} <= acc + rf[rsel]
//          10 ST   rf[rsel] <= acc
//          11 CLR  acc <= 0, carry <= 0
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   instr_valid  instruction present on op/rsel/imm
//   instr_ready  high exactly while the sequencer is idle
//   op           opcode
//   rsel         target/source register index
//   imm          immediate used by LDI
//   rf_d         register file write data (registered)
//   rf_n         register file shared address (registered)
//   rf_w         register file write enable (registered)
//   rf_q         register file combinational read data
//   acc          accumulator
//   carry        carry out of the most recent ADD
//   done         one-cycle pulse when an instruction completes
// ---------------------------------------------------------------------------
module regfile_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [1:0]    op,
  input  logic [AW-1:0] rsel,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] rf_d,
  output logic [AW-1:0] rf_n,
  output logic          rf_w,
  input  logic [DW-1:0] rf_q,
  output logic [DW-1:0] acc,
  output logic          carry,
  output logic          done
);

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  // The operand is zero-extended by one bit so the carry falls out as bit DW
  // of the sum.
  logic [DW:0] sum;

  assign sum = {1'b0, acc} + {1'b0, rf_q};

  // Single sequencer process. Every output is registered and set one edge
  // ahead of the state in which it must be visible, so rf_w is high during
  // WR and done is high during DONE. instr_ready mirrors "state == IDLE" and
  // is forced high by reset together with the state.
  // rf_n and rf_d keep their last values in IDLE; only the accept edge
  // reloads them, which is where rsel/imm are captured.
  // Reset clears rf_w asynchronously so a write that was in flight never
  // reaches the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      rf_d        <= '0;
      rf_n        <= '0;
      rf_w        <= 1'b0;
      acc         <= '0;
      carry       <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          rf_w <= 1'b0;
          if (instr_valid) begin
            rf_n        <= rsel;
            instr_ready <= 1'b0;
            case (op)
              OP_LDI: begin
                rf_d  <= imm;
                rf_w  <= 1'b1;
                state <= WR;
              end
              OP_ST: begin
                // acc does not change during WR, so sampling it here is
                // the same value the write would see one cycle later.
                rf_d  <= acc;
                rf_w  <= 1'b1;
                state <= WR;
              end
              OP_ADD: begin
                state <= RD;
              end
              default: begin
                // CLR takes effect on the accept edge and skips straight
                // to the completion cycle.
                acc   <= '0;
                carry <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            endcase
          end
        end

        RD: begin
          // rf_n has been stable for the whole cycle, so rf_q holds the
          // selected register (including a write committed earlier).
          {carry, acc} <= sum;
          done         <= 1'b1;
          state        <= DONE;
        end

        WR: begin
          rf_w  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          rf_w        <= 1'b0;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_ctrl
//
// Bench for regfile_ctrl. A behavioural 8x8 register file is attached to
// the sequencer. The driver issues directed instructions with hand-computed
// expected accumulator/carry values and pushes the expected write and the
// expected completion into two queues; independent monitors pop and compare
// whenever the DUT shows rf_w or done.
// ---------------------------------------------------------------------------
module tb_regfile_ctrl;

  localparam logic [1:0] LDI = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] ST  = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] op;
  logic [2:0] rsel;
  logic [7:0] imm;
  logic [7:0] rf_d;
  logic [2:0] rf_n;
  logic       rf_w;
  logic [7:0] rf_q;
  logic [7:0] acc;
  logic       carry;
  logic       done;

  typedef struct {
    logic [2:0] n;
    logic [7:0] d;
  } wr_exp_t;

  typedef struct {
    logic [7:0] acc;
    logic       carry;
    int         cyc;
  } done_exp_t;

  wr_exp_t   wr_q[$];
  done_exp_t done_q[$];

  logic [7:0] mem [8];
  int cyc;
  int checks;
  int errors;

  regfile_ctrl #(.DW(8), .AW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op          (op),
    .rsel        (rsel),
    .imm         (imm),
    .rf_d        (rf_d),
    .rf_n        (rf_n),
    .rf_w        (rf_w),
    .rf_q        (rf_q),
    .acc         (acc),
    .carry       (carry),
    .done        (done)
  );

  // Clock and free-running cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file: synchronous write, combinational read,
  // not reset by the sequencer's reset.
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
  end
  always @(posedge clk) if (rf_w) mem[rf_n] <= rf_d;
  assign rf_q = mem[rf_n];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (rf_w === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write_addr", int'(rf_n), -1);
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        check("write_addr", int'(rf_n), int'(e.n));
        check("write_data", int'(rf_d), int'(e.d));
      end
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        check("unexpected_done_cycle", cyc, -1);
      end else begin
        done_exp_t e;
        e = done_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("done_acc", int'(acc), int'(e.acc));
        check("done_carry", int'(carry), int'(e.carry));
      end
    end
  end

  // Static output check used while idle or in reset
  task automatic checkOutput(input string tag, input logic [7:0] exp_acc);
    check({tag, "_ready"}, int'(instr_ready), 1);
    check({tag, "_rf_w"}, int'(rf_w), 0);
    check({tag, "_acc"}, int'(acc), int'(exp_acc));
    check({tag, "_carry"}, int'(carry), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // Present one instruction (called at a falling edge) and hold it until
  // accepted. exp_wait is the number of cycles instr_ready must stay low
  // before acceptance. Returns at the falling edge of cycle 1; instr_valid
  // is left high.
  task automatic applyStimulus(input logic [1:0] o, input logic [2:0] r,
                               input logic [7:0] i, input logic [7:0] exp_acc,
                               input logic exp_carry, input int exp_wait,
                               input bit exp_done);
    int waited;
    instr_valid = 1'b1;
    op          = o;
    rsel        = r;
    imm         = i;
    waited      = 0;
    while (instr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (instr_ready !== 1'b1) begin
      check("accept_timeout", waited, exp_wait);
    end else begin
      check("accept_wait", waited, exp_wait);
      if (o == LDI) wr_q.push_back('{n: r, d: i});
      if (o == ST)  wr_q.push_back('{n: r, d: exp_acc});
      if (exp_done)
        done_q.push_back('{acc: exp_acc, carry: exp_carry, cyc: cyc + ((o == CLR) ? 1 : 2)});
    end
    @(negedge clk);
  endtask

  initial begin
    int guard;
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    instr_valid = 1'b1;
    op          = LDI;
    rsel        = 3'd3;
    imm         = 8'h5A;

    // Reset held with a pending instruction
    repeat (4) begin
      @(negedge clk);
      checkOutput("reset", 8'h00);
    end
    rst = 1'b1;

    // Load and accumulate, wrap and carry, store and read back, clear
    applyStimulus(LDI, 3'd3, 8'h5A, 8'h00, 1'b0, 0, 1'b1);
    applyStimulus(ADD, 3'd3, 8'h00, 8'h5A, 1'b0, 2, 1'b1);
    applyStimulus(LDI, 3'd1, 8'hF0, 8'h5A, 1'b0, 2, 1'b1);
    applyStimulus(ADD, 3'd1, 8'h00, 8'h4A, 1'b1, 2, 1'b1);
    applyStimulus(ST,  3'd7, 8'h00, 8'h4A, 1'b1, 2, 1'b1);
    applyStimulus(ADD, 3'd7, 8'h00, 8'h94, 1'b0, 2, 1'b1);
    applyStimulus(CLR, 3'd0, 8'h00, 8'h00, 1'b0, 2, 1'b1);

    // Back-to-back LDIs with instr_valid held high throughout
    applyStimulus(LDI, 3'd0, 8'h11, 8'h00, 1'b0, 1, 1'b1);
    applyStimulus(LDI, 3'd4, 8'h22, 8'h00, 1'b0, 2, 1'b1);
    applyStimulus(LDI, 3'd5, 8'h33, 8'h00, 1'b0, 2, 1'b1);
    applyStimulus(LDI, 3'd6, 8'h44, 8'h00, 1'b0, 2, 1'b1);
    applyStimulus(ADD, 3'd5, 8'h00, 8'h33, 1'b0, 2, 1'b1);
    applyStimulus(ADD, 3'd6, 8'h00, 8'h77, 1'b0, 2, 1'b1);

    // Reset in the middle of the WR cycle of LDI r2=0xAA
    applyStimulus(LDI, 3'd2, 8'hAA, 8'h77, 1'b0, 2, 1'b0);
    check("rf_w_before_reset", int'(rf_w), 1);
    check("acc_before_reset", int'(acc), 8'h77);
    instr_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("midreset_rf_w", int'(rf_w), 0);
    check("midreset_acc", int'(acc), 8'h00);
    check("midreset_ready", int'(instr_ready), 1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("midreset", 8'h00);
    end
    check("r2_not_written", int'(mem[2]), 8'h00);
    rst = 1'b1;

    // r2 still holds zero, so the accumulator stays at zero
    applyStimulus(ADD, 3'd2, 8'h00, 8'h00, 1'b0, 0, 1'b1);
    instr_valid = 1'b0;

    guard = 0;
    while ((done_q.size() != 0 || wr_q.size() != 0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("pending_writes", wr_q.size(), 0);
    check("pending_dones", done_q.size(), 0);
    check("final_r7", int'(mem[7]), 8'h4A);
    check("final_r0", int'(mem[0]), 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
